// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller with a glitch-free gated scan-clock decode, instruction
// selection, a bypass bit and the TDO mux.
module tap_ctrl (
  input  logic       ck,
  input  logic       reset_n,
  input  logic       TMS,
  input  logic       TDI,
  input  logic [1:0] inst,
  input  logic       tdo_ir,
  input  logic       tdo_bsr,
  output logic       TDO,
  output logic       clockdr,
  output logic       updatedr,
  output logic       shiftdr,
  output logic       clockir,
  output logic       updateir,
  output logic       shiftir,
  output logic       hold,
  output logic [1:0] sel,
  output logic [3:0] tap_state
);

  localparam logic [3:0] TLR    = 4'hF;
  localparam logic [3:0] RTI    = 4'hC;
  localparam logic [3:0] SEL_DR = 4'h7;
  localparam logic [3:0] CAP_DR = 4'h6;
  localparam logic [3:0] SH_DR  = 4'h2;
  localparam logic [3:0] EX1_DR = 4'h1;
  localparam logic [3:0] PAU_DR = 4'h3;
  localparam logic [3:0] EX2_DR = 4'h0;
  localparam logic [3:0] UPD_DR = 4'h5;
  localparam logic [3:0] SEL_IR = 4'h4;
  localparam logic [3:0] CAP_IR = 4'hE;
  localparam logic [3:0] SH_IR  = 4'hA;
  localparam logic [3:0] EX1_IR = 4'h9;
  localparam logic [3:0] PAU_IR = 4'hB;
  localparam logic [3:0] EX2_IR = 4'h8;
  localparam logic [3:0] UPD_IR = 4'hD;

  localparam logic [1:0] EXTEST  = 2'b00;
  localparam logic [1:0] INTSCAN = 2'b10;
  localparam logic [1:0] BYPASS  = 2'b11;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       bypass_bit;
  logic       dr_clk_en;
  logic       ir_clk_en;
  logic       dr_upd_en;
  logic       ir_upd_en;

  // State register; reset overrides TMS in every state
  always_ff @(posedge ck) begin
    if (!reset_n) state <= TLR;
    else          state <= state_nxt;
  end

  // Next-state function
  always_comb begin
    state_nxt = state;
    case (state)
      TLR:    state_nxt = TMS ? TLR    : RTI;
      RTI:    state_nxt = TMS ? SEL_DR : RTI;
      SEL_DR: state_nxt = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_nxt = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_nxt = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_nxt = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_nxt = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_nxt = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_nxt = TMS ? SEL_DR : RTI;
      SEL_IR: state_nxt = TMS ? TLR    : CAP_IR;
      CAP_IR: state_nxt = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_nxt = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_nxt = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_nxt = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_nxt = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_nxt = TMS ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  // Bypass bit only moves when BYPASS is the effective instruction
  always_ff @(posedge ck) begin
    if (!reset_n) begin
      bypass_bit <= 1'b0;
    end else if (sel == BYPASS) begin
      if (state == CAP_DR)     bypass_bit <= 1'b0;
      else if (state == SH_DR) bypass_bit <= TDI;
    end
  end

  // Moore decodes, instruction select and TDO mux
  always_comb begin
    shiftdr   = 1'b0;
    shiftir   = 1'b0;
    dr_clk_en = 1'b0;
    ir_clk_en = 1'b0;
    dr_upd_en = 1'b0;
    ir_upd_en = 1'b0;
    sel       = inst;
    TDO       = 1'b0;
    if (state == TLR) sel = BYPASS;
    hold = (sel == EXTEST) || (sel == INTSCAN);
    case (state)
      CAP_DR: dr_clk_en = 1'b1;
      SH_DR: begin
        shiftdr   = 1'b1;
        dr_clk_en = 1'b1;
        TDO       = (sel == BYPASS) ? bypass_bit : tdo_bsr;
      end
      UPD_DR: dr_upd_en = 1'b1;
      CAP_IR: ir_clk_en = 1'b1;
      SH_IR: begin
        shiftir   = 1'b1;
        ir_clk_en = 1'b1;
        TDO       = tdo_ir;
      end
      UPD_IR: ir_upd_en = 1'b1;
      default: ;
    endcase
  end

  // Enables only change after ck rises, so the low phase of ck sees a stable enable
  assign clockdr   = ~ck & dr_clk_en;
  assign clockir   = ~ck & ir_clk_en;
  assign updatedr  = ~ck & dr_upd_en;
  assign updateir  = ~ck & ir_upd_en;
  assign tap_state = state;

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed bench for tap_ctrl: reset, IR and DR scans, bypass path, mid-shift
// reset and the five-TMS=1 return from every state.
module tb_tap_ctrl;

  logic       ck = 1'b0;
  logic       reset_n;
  logic       TMS;
  logic       TDI;
  logic [1:0] inst;
  logic       tdo_ir;
  logic       tdo_bsr;
  logic       TDO;
  logic       clockdr;
  logic       updatedr;
  logic       shiftdr;
  logic       clockir;
  logic       updateir;
  logic       shiftir;
  logic       hold;
  logic [1:0] sel;
  logic [3:0] tap_state;

  int checks = 0;
  int errors = 0;
  int n_clkdr = 0;
  int n_clkir = 0;
  int n_upddr = 0;
  int n_updir = 0;
  int base_dr, base_ir, base_udr, base_uir;

  tap_ctrl dut (
    .ck(ck), .reset_n(reset_n), .TMS(TMS), .TDI(TDI), .inst(inst),
    .tdo_ir(tdo_ir), .tdo_bsr(tdo_bsr), .TDO(TDO),
    .clockdr(clockdr), .updatedr(updatedr), .shiftdr(shiftdr),
    .clockir(clockir), .updateir(updateir), .shiftir(shiftir),
    .hold(hold), .sel(sel), .tap_state(tap_state)
  );

  always #5 ck = ~ck;

  always @(posedge clockdr)  n_clkdr++;
  always @(posedge clockir)  n_clkir++;
  always @(posedge updatedr) n_upddr++;
  always @(posedge updateir) n_updir++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply TMS, then settle 1 time unit past the next rising edge
  task automatic tick(input logic tms);
    TMS = tms;
    @(posedge ck);
    #1;
  endtask

  task automatic snap();
    base_dr  = n_clkdr;
    base_ir  = n_clkir;
    base_udr = n_upddr;
    base_uir = n_updir;
  endtask

  logic [3:0] codes [16];
  logic [7:0] pbits [16];
  int         plen  [16];

  initial begin
    codes = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
              4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    pbits = '{8'b0, 8'b0, 8'b10, 8'b010, 8'b0010, 8'b1010, 8'b01010, 8'b101010,
              8'b11010, 8'b110, 8'b0110, 8'b00110, 8'b10110, 8'b010110, 8'b1010110, 8'b110110};
    plen  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

    reset_n = 1'b0; TMS = 1'b0; TDI = 1'b0; inst = 2'b11; tdo_ir = 1'b0; tdo_bsr = 1'b0;
    @(posedge ck); #1;
    tick(1'b0);
    // Reset state observed while reset is still asserted
    chk("rst_state", 32'(tap_state), 32'hF);
    chk("rst_sel", 32'(sel), 32'h3);
    chk("rst_hold", 32'(hold), 32'h0);
    chk("rst_shift", 32'({shiftdr, shiftir}), 32'h0);
    tdo_ir = 1'b1; tdo_bsr = 1'b1;
    @(negedge ck); #1;
    chk("rst_tdo", 32'(TDO), 32'h0);
    chk("rst_clks", 32'({clockdr, clockir, updatedr, updateir}), 32'h0);
    tdo_ir = 1'b0; tdo_bsr = 1'b0;

    // Leave reset, one TMS=0 -> RTI
    reset_n = 1'b1;
    tick(1'b0);
    chk("rti_state", 32'(tap_state), 32'hC);
    chk("rti_hold", 32'(hold), 32'h0);
    chk("rti_sel", 32'(sel), 32'h3);

    // IR scan: capture + 3 shift cycles, then update
    snap();
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
    chk("shir_state", 32'(tap_state), 32'hA);
    chk("shir_shiftir", 32'(shiftir), 32'h1);
    tdo_ir = 1'b1; #1;
    chk("shir_tdo1", 32'(TDO), 32'h1);
    tdo_ir = 1'b0; #1;
    chk("shir_tdo0", 32'(TDO), 32'h0);
    tick(1'b0); tick(1'b0); tick(1'b1);
    chk("ex1ir_state", 32'(tap_state), 32'h9);
    chk("ex1ir_shiftir", 32'(shiftir), 32'h0);
    tick(1'b1); tick(1'b0);
    chk("ir_state_end", 32'(tap_state), 32'hC);
    chk("ir_clockir_cnt", 32'(n_clkir - base_ir), 32'd4);
    chk("ir_updateir_cnt", 32'(n_updir - base_uir), 32'd1);
    chk("ir_clockdr_cnt", 32'(n_clkdr - base_dr), 32'd0);

    // DR scan with EXTEST: capture + 8 shifts, pause, update
    inst = 2'b00;
    #1;
    chk("ext_sel", 32'(sel), 32'h0);
    snap();
    tick(1'b1); tick(1'b0);
    chk("capdr_state", 32'(tap_state), 32'h6);
    @(negedge ck); #1;
    chk("capdr_clockdr_lvl", 32'(clockdr), 32'h1);
    tick(1'b0);
    chk("shdr_state", 32'(tap_state), 32'h2);
    chk("shdr_shiftdr", 32'(shiftdr), 32'h1);
    chk("shdr_hold", 32'(hold), 32'h1);
    for (int i = 0; i < 8; i++) begin
      tdo_bsr = ((8'b1011_0010 >> i) & 8'h1) != 0;
      #1;
      chk($sformatf("bsr_tdo%0d", i), 32'(TDO), 32'(tdo_bsr));
      tick(i == 7);
    end
    tdo_bsr = 1'b1;
    chk("ex1dr_state", 32'(tap_state), 32'h1);
    chk("ex1dr_tdo", 32'(TDO), 32'h0);
    tick(1'b0);
    chk("paudr_state", 32'(tap_state), 32'h3);
    @(negedge ck); #1;
    chk("paudr_clk_lvl", 32'({clockdr, shiftdr}), 32'h0);
    tick(1'b0); tick(1'b1);
    chk("ex2dr_state", 32'(tap_state), 32'h0);
    tick(1'b1); tick(1'b0);
    chk("dr_state_end", 32'(tap_state), 32'hC);
    chk("dr_clockdr_cnt", 32'(n_clkdr - base_dr), 32'd9);
    chk("dr_updatedr_cnt", 32'(n_upddr - base_udr), 32'd1);
    tdo_bsr = 1'b0;

    // Other instructions drive hold as decoded
    inst = 2'b01; #1;
    chk("sample_hold", 32'(hold), 32'h0);
    inst = 2'b10; #1;
    chk("intscan_hold", 32'(hold), 32'h1);

    // BYPASS: TDI 1,0,1 -> TDO 0,1,0, then recapture 0 over a stored 1
    inst = 2'b11;
    tick(1'b1); tick(1'b0); tick(1'b0);
    chk("byp_hold", 32'(hold), 32'h0);
    tdo_bsr = 1'b1;
    TDI = 1'b1; #1;
    chk("byp_tdo0", 32'(TDO), 32'h0);
    tick(1'b0);
    TDI = 1'b0; #1;
    chk("byp_tdo1", 32'(TDO), 32'h1);
    tick(1'b0);
    TDI = 1'b1; #1;
    chk("byp_tdo2", 32'(TDO), 32'h0);
    tick(1'b1);
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
    chk("byp_re_state", 32'(tap_state), 32'h2);
    chk("byp_recapture", 32'(TDO), 32'h0);

    // SAMPLE in ShDR follows tdo_bsr, not the bypass bit
    inst = 2'b01; tdo_bsr = 1'b1; #1;
    chk("sample_tdo", 32'(TDO), 32'h1);
    inst = 2'b11; tdo_bsr = 1'b0;

    // Reset for one cycle during ShDR
    reset_n = 1'b0;
    tick(1'b0);
    chk("midrst_state", 32'(tap_state), 32'hF);
    chk("midrst_shiftdr", 32'(shiftdr), 32'h0);
    snap();
    reset_n = 1'b1;
    tick(1'b1);
    chk("midrst_no_clockdr", 32'(n_clkdr - base_dr), 32'd0);
    chk("midrst_state2", 32'(tap_state), 32'hF);

    // Five TMS=1 cycles reach TLR from every state
    for (int s = 0; s < 16; s++) begin
      reset_n = 1'b0;
      tick(1'b0);
      reset_n = 1'b1;
      for (int k = 0; k < plen[s]; k++) tick(pbits[s][k]);
      chk($sformatf("walk_state%0d", s), 32'(tap_state), 32'(codes[s]));
      for (int k = 0; k < 5; k++) tick(1'b1);
      chk($sformatf("tms5_tlr%0d", s), 32'(tap_state), 32'hF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
